// File: rtl/lifo_stack.sv
// Register-based LIFO stack with replace-top (push+pop), flush and sticky
// overflow/underflow flags. Top of stack is read combinationally.
module lifo_stack #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      next_count;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_addr;
    logic             wr_en;
    logic             ovf_evt;
    logic             unf_evt;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign top_idx = AW'(count - 1'b1);
    assign dout    = empty ? '0 : mem[top_idx];

    always_comb begin
        next_count = count;
        wr_en      = 1'b0;
        wr_addr    = AW'(count);
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        if (flush) begin
            next_count = '0;
        end else if (push && pop) begin
            // Replace-top; on an empty stack this degenerates to a plain push.
            wr_en = 1'b1;
            if (empty) begin
                next_count = count + 1'b1;
            end else begin
                wr_addr = top_idx;
            end
        end else if (push) begin
            if (full) begin
                ovf_evt = 1'b1;
            end else begin
                wr_en      = 1'b1;
                next_count = count + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                unf_evt = 1'b1;
            end else begin
                next_count = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= next_count;
            // A new event wins over a simultaneous clear.
            overflow  <= ovf_evt | (overflow & ~err_clr);
            underflow <= unf_evt | (underflow & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= din;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack: directed literal checks plus a random soak compared
// every cycle against a queue-based stack model.
module tb_lifo_stack;

    localparam int WIDTH = 11;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk;
    logic             rst, push, pop, flush, err_clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [AW:0]      count;
    logic             empty, full, overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    logic [WIDTH-1:0] m_stk [$];
    bit               m_ovf, m_unf;

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
        .err_clr(err_clr), .din(din), .dout(dout), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model step: applies the stack rules to the inputs sampled at this edge.
    task automatic model_update();
        bit ovf_ev = 0, unf_ev = 0;
        if (rst) begin
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        if (flush) m_stk.delete();
        else if (push && pop) begin
            if (m_stk.size() == 0) m_stk.push_back(din);
            else m_stk[m_stk.size()-1] = din;
        end else if (push) begin
            if (m_stk.size() == DEPTH) ovf_ev = 1;
            else m_stk.push_back(din);
        end else if (pop) begin
            if (m_stk.size() == 0) unf_ev = 1;
            else void'(m_stk.pop_back());
        end
        m_ovf = ovf_ev || (m_ovf && !err_clr);
        m_unf = unf_ev || (m_unf && !err_clr);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit r, input bit pu, input bit po, input bit fl,
                        input bit ec, input logic [WIDTH-1:0] d);
        rst = r; push = pu; pop = po; flush = fl; err_clr = ec; din = d;
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst = 0; push = 0; pop = 0; flush = 0; err_clr = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_count", 32'(count), 32'(m_stk.size()));
            check("model_dout", 32'(dout), (m_stk.size() == 0) ? 32'd0 : 32'(m_stk[m_stk.size()-1]));
            check("model_empty", 32'(empty), 32'(m_stk.size() == 0));
            check("model_full", 32'(full), 32'(m_stk.size() == DEPTH));
            check("model_ovf", 32'(overflow), 32'(m_ovf));
            check("model_unf", 32'(underflow), 32'(m_unf));
        end
    end

    initial begin
        rst = 1; push = 0; pop = 0; flush = 0; err_clr = 0; din = '0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        chk_en = 1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_dout", 32'(dout), 0);

        // Fill then overflow
        for (int i = 1; i <= 16; i++) step(0, 1, 0, 0, 0, 11'(i));
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 16);
        check("fill_dout", 32'(dout), 32'h010);
        check("fill_ovf", 32'(overflow), 0);
        step(0, 1, 0, 0, 0, 11'h7FF);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_dout", 32'(dout), 32'h010);
        // Full replace-top flags nothing; err_clr with a new overflow keeps it set
        step(0, 1, 0, 0, 1, 11'h7FF);
        check("ovf_clr_collide", 32'(overflow), 1);
        step(0, 1, 1, 0, 0, 11'h010);
        check("rtop_full_count", 32'(count), 16);

        // Drain and underflow
        for (int i = 15; i >= 0; i--) begin
            step(0, 0, 1, 0, 0, 0);
            check("drain_dout", 32'(dout), 32'(i));
        end
        check("drain_empty", 32'(empty), 1);
        step(0, 0, 1, 0, 0, 0);
        check("unf_set", 32'(underflow), 1);
        check("unf_count", 32'(count), 0);
        step(0, 0, 0, 0, 1, 0);
        check("clr_ovf", 32'(overflow), 0);
        check("clr_unf", 32'(underflow), 0);

        // Replace-top
        step(0, 1, 0, 0, 0, 11'h0AA);
        step(0, 1, 0, 0, 0, 11'h0BB);
        step(0, 1, 1, 0, 0, 11'h0CC);
        check("rtop_count", 32'(count), 2);
        check("rtop_dout", 32'(dout), 32'h0CC);
        step(0, 0, 1, 0, 0, 0);
        check("rtop_pop_dout", 32'(dout), 32'h0AA);

        // Push+pop on empty
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 11'h123);
        check("pp_empty_count", 32'(count), 1);
        check("pp_empty_dout", 32'(dout), 32'h123);
        check("pp_empty_unf", 32'(underflow), 0);

        // Flush priority over push
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 11'(i + 3));
        check("pre_flush_count", 32'(count), 5);
        step(0, 1, 0, 1, 0, 11'h3FF);
        check("flush_count", 32'(count), 0);
        check("flush_empty", 32'(empty), 1);
        check("flush_ovf", 32'(overflow), 0);
        step(0, 1, 0, 0, 0, 11'h055);
        check("post_flush_count", 32'(count), 1);
        check("post_flush_dout", 32'(dout), 32'h055);

        // Reset mid-sequence with flags set, count 7
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 0, 11'(i + 32));
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0, 0);
        check("pre_rst_count", 32'(count), 7);
        check("pre_rst_ovf", 32'(overflow), 1);
        step(1, 1, 0, 0, 0, 11'h2A2);
        check("midrst_count", 32'(count), 0);
        check("midrst_ovf", 32'(overflow), 0);
        check("midrst_unf", 32'(underflow), 0);
        step(0, 1, 0, 0, 0, 11'h321);
        check("midrst_push_dout", 32'(dout), 32'h321);
        check("midrst_push_count", 32'(count), 1);

        // Random soak
        for (int i = 0; i < 3000; i++) begin
            int r = int'($urandom_range(0, 99));
            step($urandom_range(0, 199) == 0, r < 55, (r >= 40) && (r < 90),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
                 11'($urandom));
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
